icache_fetch_responder: RTL and testbench

- Responder side of the fetch interface: takes the fetch PC each cycle and returns a 128-bit instruction window with inst slot0 = instruction at pc.
- Raises cache_un_ready while it refills a missing line from memory.
- Direct-mapped instruction cache, 16-byte lines, sits between the PC/fetch stage and the memory bus.

---
 rtl/icache_fetch_responder_pkg.sv | 26 ++
 rtl/icache_window_shift.sv | 22 ++
 rtl/icache_fetch_responder.sv | 157 +++++++++++++++
 tb/tb_icache_fetch_responder.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_fetch_responder_pkg.sv
// Shared constants, state encoding and helpers for the fetch-side instruction cache.
// Included by icache_fetch_responder and icache_window_shift.
package icache_fetch_responder_pkg;

  localparam int PCBUS       = 64;
  localparam int DATABUS     = 64;
  localparam int LINE_BYTES  = 16;
  localparam int LINE_WORDS  = 4;
  localparam int LINE_OFS_W  = $clog2(LINE_BYTES);
  localparam int WINDOW_W    = 32 * LINE_WORDS;

  localparam logic [31:0] ZEROWORD = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    BEAT0 = 3'd2,
    BEAT1 = 3'd3,
    FILL  = 3'd4
  } state_e;

  function automatic logic [PCBUS-1:0] line_align(input logic [PCBUS-1:0] addr);
    return {addr[PCBUS-1:LINE_OFS_W], {LINE_OFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_window_shift.sv
// Selects the instruction window inside a 16-byte line: word at pc lands in slot 0,
// slots that would run past the end of the line are zero.
module icache_window_shift
  import icache_fetch_responder_pkg::*;
(
  input  logic [WINDOW_W-1:0] line,
  input  logic [1:0]          offset,
  output logic [WINDOW_W-1:0] window
);

  always_comb begin
    window = '0;
    case (offset)
      2'd0: window = line;
      2'd1: window = {ZEROWORD, line[127:32]};
      2'd2: window = {ZEROWORD, ZEROWORD, line[127:64]};
      2'd3: window = {ZEROWORD, ZEROWORD, ZEROWORD, line[127:96]};
      default: window = '0;
    endcase
  end

endmodule

// File: rtl/icache_fetch_responder.sv
// Direct-mapped instruction cache answering the fetch stage with a 128-bit window.
// Define ICACHE_STATS_EN to add the hit_cnt_o / miss_cnt_o lookup counters.
module icache_fetch_responder
  import icache_fetch_responder_pkg::*;
#(
  parameter int          SETS        = 64,
  parameter logic [63:0] RST_PC_LINE = 64'h0000_0000_8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PCBUS-1:0]    pc_i,
  input  logic                pc_valid_i,
  input  logic                flush_i,
  output logic [WINDOW_W-1:0] inst_o,
  output logic                cache_un_ready,
  output logic                mem_req_o,
  output logic [PCBUS-1:0]    mem_addr_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATABUS-1:0]  mem_rdata_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]         hit_cnt_o,
  output logic [31:0]         miss_cnt_o
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = PCBUS - LINE_OFS_W - IDX_W;

  state_e               state;
  logic [SETS-1:0]      valid;
  logic [TAG_W-1:0]     tag_mem  [SETS];
  logic [WINDOW_W-1:0]  data_mem [SETS];
  logic [DATABUS-1:0]   beat0_q;
  logic [DATABUS-1:0]   beat1_q;
  logic                 kill;

  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic [IDX_W-1:0]     fill_idx;
  logic [TAG_W-1:0]     fill_tag;
  logic                 hit;
  logic                 lookup;
  logic                 miss;
  logic [WINDOW_W-1:0]  rd_line;
  logic [WINDOW_W-1:0]  window;
  logic                 unused_bits;

  assign idx      = pc_i[LINE_OFS_W +: IDX_W];
  assign tag      = pc_i[PCBUS-1 -: TAG_W];
  assign fill_idx = mem_addr_o[LINE_OFS_W +: IDX_W];
  assign fill_tag = mem_addr_o[PCBUS-1 -: TAG_W];
  assign rd_line  = data_mem[idx];

  // A flush in the lookup cycle forces a miss even if the old line was valid.
  assign hit    = valid[idx] && (tag_mem[idx] == tag) && !flush_i;
  assign lookup = (state == IDLE) && pc_valid_i;
  assign miss   = lookup && !hit;

  icache_window_shift u_window_shift (
    .line   (rd_line),
    .offset (pc_i[3:2]),
    .window (window)
  );

  // Outputs are gated by rst so they drop as soon as reset asserts, not at the next edge.
  assign inst_o         = (!rst && lookup && hit) ? window : '0;
  assign cache_un_ready = !rst && ((state != IDLE) || miss);

  assign unused_bits = ^{pc_i[1:0], RST_PC_LINE};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      valid      <= '0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      kill       <= 1'b0;
    end else begin
      if (flush_i) begin
        valid <= '0;
      end else if (state == FILL && !kill) begin
        valid[fill_idx] <= 1'b1;
      end

      // A flush seen while a refill is in flight must keep that line invalid.
      if (flush_i && state != IDLE) begin
        kill <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (miss) begin
            state      <= REQ;
            mem_req_o  <= 1'b1;
            mem_addr_o <= line_align(pc_i);
            kill       <= 1'b0;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state     <= BEAT0;
          end
        end
        BEAT0: begin
          if (mem_rvalid_i) begin
            state <= BEAT1;
          end
        end
        BEAT1: begin
          if (mem_rvalid_i) begin
            state <= FILL;
          end
        end
        FILL: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

  // Line storage is not reset; the valid bits alone decide whether it is used.
  always_ff @(posedge clk) begin
    if (state == BEAT0 && mem_rvalid_i) begin
      beat0_q <= mem_rdata_i;
    end
    if (state == BEAT1 && mem_rvalid_i) begin
      beat1_q <= mem_rdata_i;
    end
    if (state == FILL) begin
      data_mem[fill_idx] <= {beat1_q, beat0_q};
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (lookup) begin
      if (hit) begin
        hit_cnt_o <= hit_cnt_o + 32'd1;
      end else begin
        miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Randomised and directed bench for icache_fetch_responder with a line-level cache model,
// a memory responder and a window scoreboard.
module tb_icache_fetch_responder;
  import icache_fetch_responder_pkg::*;

  localparam int SETS = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   pc_i;
  logic          pc_valid_i;
  logic          flush_i;
  logic [127:0]  inst_o;
  logic          cache_un_ready;
  logic          mem_req_o;
  logic [63:0]   mem_addr_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [63:0]   mem_rdata_i;
`ifdef ICACHE_STATS_EN
  logic [31:0]   hit_cnt_o;
  logic [31:0]   miss_cnt_o;
`endif

  always #5 clk = ~clk;

  icache_fetch_responder #(.SETS(SETS)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_i           (pc_i),
    .pc_valid_i     (pc_valid_i),
    .flush_i        (flush_i),
    .inst_o         (inst_o),
    .cache_un_ready (cache_un_ready),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt_o      (hit_cnt_o),
    .miss_cnt_o     (miss_cnt_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_q[$];
  logic [63:0]  exp_addr_q[$];

  bit fast_mem = 1'b1;
  bit mem_pause = 1'b0;
  bit flush_at_beat1 = 1'b0;

  logic [63:0] model_line [SETS];
  bit          model_valid [SETS];
  int          hits_m = 0;
  int          misses_m = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Backing memory contents: the first boot line holds a fixed program, the rest a hash.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if ((a & ~64'hF) == 64'h0000_0000_8000_0000)
      return (a[3:2] == 2'd3) ? 32'h0000_006f : 32'h0000_0013;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [63:0] beat_data(input logic [63:0] line, input int b);
    return {mem_word(line + 64'(8 * b + 4)), mem_word(line + 64'(8 * b))};
  endfunction

  function automatic logic [127:0] ref_window(input logic [63:0] pc);
    logic [63:0]  line;
    logic [127:0] w;
    int first;
    w = '0;
    line = pc & ~64'hF;
    first = int'(pc[3:2]);
    for (int j = 0; j < 4; j++)
      if (first + j < 4) w[32*j +: 32] = mem_word(line + 64'(4 * (first + j)));
    return w;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < SETS; i++) model_valid[i] = 1'b0;
  endfunction

  // Returns 1 when the access needs a refill; records the refill the DUT must request.
  function automatic bit model_access(input logic [63:0] pc, input bit fl);
    logic [63:0] line;
    int set;
    if (fl) model_clear();
    line = pc & ~64'hF;
    set = int'((pc >> 4) % SETS);
    if (model_valid[set] && model_line[set] == line) return 1'b0;
    exp_addr_q.push_back(line);
    model_valid[set] = 1'b1;
    model_line[set] = line;
    return 1'b1;
  endfunction

  // Window scoreboard.
  always @(negedge clk) begin
    if (!rst && pc_valid_i && !cache_un_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window: got %0h expected none", inst_o);
      end else begin
        check("window", inst_o, exp_q.pop_front());
      end
    end else if (!rst && !pc_valid_i && !cache_un_ready) begin
      check("idle_zero", inst_o, 128'h0);
    end
  end

  // Memory responder; checks every refill address against the model.
  initial begin
    logic [63:0] line;
    int gap;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      if (rst || mem_pause) begin
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
      end else if (mem_req_o) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got %0h expected none", mem_addr_o);
        end else begin
          check("refill_addr", mem_addr_o, exp_addr_q.pop_front());
        end
        gap = fast_mem ? 0 : $urandom_range(0, 2);
        repeat (gap) begin
          mem_gnt_i = 1'b0;
          mem_rvalid_i = 1'($urandom_range(0, 1));
          mem_rdata_i = {$urandom, $urandom};
          @(posedge clk); #1;
          check("req_hold", mem_req_o, 1'b1);
        end
        line = mem_addr_o;
        mem_gnt_i = 1'b1;
        mem_rvalid_i = 1'b0;
        @(posedge clk); #1;
        mem_gnt_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
          gap = fast_mem ? 0 : $urandom_range(0, 1);
          repeat (gap) begin
            mem_rvalid_i = 1'b0;
            @(posedge clk); #1;
          end
          mem_rvalid_i = 1'b1;
          mem_rdata_i = beat_data(line, b);
          if (b == 1 && flush_at_beat1) flush_i = 1'b1;
          @(posedge clk); #1;
          if (b == 1 && flush_at_beat1) begin
            flush_i = 1'b0;
            flush_at_beat1 = 1'b0;
          end
        end
        mem_rvalid_i = 1'b0;
      end else begin
        mem_gnt_i = 1'b0;
        mem_rvalid_i = fast_mem ? 1'b0 : 1'($urandom_range(0, 1));
        mem_rdata_i = {$urandom, $urandom};
      end
    end
  end

  // Entered just after a rising edge; returns just after the edge that ends the accepted cycle.
  task automatic wait_accept(output int ur, input bit drop_flush);
    bit acc;
    acc = 1'b0;
    ur = 0;
    for (int n = 0; n < 400 && !acc; n++) begin
      @(negedge clk);
      acc = !cache_un_ready;
      if (!acc) ur++;
      @(posedge clk); #1;
      if (drop_flush) flush_i = 1'b0;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got busy expected ready within 400 cycles");
    end
  endtask

  task automatic fetch(input logic [63:0] pc, input bit fl);
    bit miss;
    int ur;
    pc_i = pc;
    pc_valid_i = 1'b1;
    flush_i = fl;
    miss = model_access(pc, fl);
    if (miss) misses_m++;
    hits_m++;
    exp_q.push_back(ref_window(pc));
    wait_accept(ur, fl);
    if (fast_mem) check_int("latency", ur, miss ? 5 : 0);
    else check_int("stall", (ur > 0) ? 1 : 0, miss ? 1 : 0);
  endtask

  initial begin
    int ur;
    int idle;
    logic [63:0] pc;
    logic [63:0] tag_base [4];
    int set_pick [4];
    tag_base = '{64'h0000_0000_8000_0000, 64'h0000_0000_8000_0400,
                 64'h0000_0000_8000_1000, 64'h8000_0000_8000_0000};
    set_pick = '{0, 1, 2, SETS - 1};
    model_clear();

    rst = 1'b1;
    pc_i = '0;
    pc_valid_i = 1'b0;
    flush_i = 1'b0;
    #12;
    check("rst_req", mem_req_o, 1'b0);
    check("rst_addr", mem_addr_o, 64'h0);
    check("rst_un_ready", cache_un_ready, 1'b0);
    check("rst_inst", inst_o, 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Cold miss with an immediate memory, then a shifted hit in the same line.
    fetch(64'h0000_0000_8000_0000, 1'b0);
    check("cold_window", inst_o, 128'h0000006f_00000013_00000013_00000013);
    fetch(64'h0000_0000_8000_000C, 1'b0);
    check("offset_window", inst_o, 128'h00000000_00000000_00000000_0000006f);

    // Two lines sharing set 0 evict each other.
    fetch(64'h0000_0000_8000_0400, 1'b0);
    fetch(64'h0000_0000_8000_0000, 1'b0);
    pc_valid_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Redirect to a cached pc while the refill is receiving its first beat.
    pc_i = 64'h0000_0000_8000_0010;
    pc_valid_i = 1'b1;
    void'(model_access(pc_i, 1'b0));
    misses_m++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    pc_i = 64'h0000_0000_8000_0000;
    void'(model_access(pc_i, 1'b0));
    hits_m++;
    exp_q.push_back(ref_window(pc_i));
    wait_accept(ur, 1'b0);
    check_int("redirect_latency", ur, 3);
    fetch(64'h0000_0000_8000_0010, 1'b0);

    // Flush while the last beat arrives: the line must be fetched twice.
    flush_at_beat1 = 1'b1;
    pc_i = 64'h0000_0000_8000_0020;
    pc_valid_i = 1'b1;
    void'(model_access(pc_i, 1'b0));
    void'(model_access(pc_i, 1'b1));
    misses_m += 2;
    hits_m++;
    exp_q.push_back(ref_window(pc_i));
    wait_accept(ur, 1'b0);
    check_int("flush_refill_latency", ur, 10);
    fetch(64'h0000_0000_8000_0000, 1'b0);

    // Asynchronous reset while a refill request is outstanding.
    mem_pause = 1'b1;
    pc_i = 64'h0000_0000_8000_0040;
    pc_valid_i = 1'b1;
    @(negedge clk);
    check("miss_detect", cache_un_ready, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("req_before_rst", mem_req_o, 1'b1);
    check("addr_before_rst", mem_addr_o, 64'h0000_0000_8000_0040);
    #2;
    rst = 1'b1;
    pc_valid_i = 1'b0;
    #1;
    check("rst_async_req", mem_req_o, 1'b0);
    check("rst_async_un_ready", cache_un_ready, 1'b0);
    check("rst_async_addr", mem_addr_o, 64'h0);
    model_clear();
    hits_m = 0;
    misses_m = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_pause = 1'b0;
    fetch(64'h0000_0000_8000_0000, 1'b0);

    // Random traffic over conflicting lines, the top set and a high tag bit.
    fast_mem = 1'b0;
    for (int it = 0; it < 150; it++) begin
      pc = tag_base[$urandom_range(0, 3)] + 64'(16 * set_pick[$urandom_range(0, 3)])
           + 64'(4 * $urandom_range(0, 3));
      fetch(pc, $urandom_range(0, 9) == 0);
      idle = $urandom_range(0, 2);
      if (idle > 0) begin
        pc_valid_i = 1'b0;
        pc_i = {$urandom, $urandom};
        repeat (idle) begin @(posedge clk); #1; end
      end
    end

    pc_valid_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check_int("windows_drained", exp_q.size(), 0);
    check_int("refills_drained", exp_addr_q.size(), 0);
`ifdef ICACHE_STATS_EN
    check_int("hit_cnt", int'(hit_cnt_o), hits_m);
    check_int("miss_cnt", int'(miss_cnt_o), misses_m);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
